// File: rtl/mapper_banked_gen_pkg.sv
// Shared types and address-map constants for the generalised banked ROM/SRAM mapper.
package mapper_banked_gen_pkg;

  localparam int unsigned TYP_W      = 8;
  localparam int unsigned ID_W       = 4;
  localparam int unsigned SIZE_W     = 28;
  localparam int unsigned OUT_ADDR_W = 27;

  typedef enum logic [TYP_W-1:0] {
    MAPPER_NONE      = 8'd0,
    MAPPER_ASCII8    = 8'd1,
    MAPPER_ASCII16   = 8'd2,
    MAPPER_KONAMI    = 8'd3,
    MAPPER_HARRY_FOX = 8'd8
  } mapper_typ_t;

  typedef enum logic {
    BANK_DIRECT = 1'b0,
    BANK_PAIR   = 1'b1
  } bank_mode_t;

  typedef enum logic {
    StIdle = 1'b0,
    StHeld = 1'b1
  } commit_st_t;

  localparam logic [15:0] REG_LO     = 16'h6000;
  localparam logic [15:0] REG_HI     = 16'h7FFF;
  localparam logic [15:0] MAP_LO     = 16'h4000;
  localparam logic [15:0] MAP_HI     = 16'hBFFF;
  localparam logic [15:0] SRAM_WR_LO = 16'h8000;
  localparam logic [15:0] SRAM_WR_HI = 16'hBFFF;

  // Index of the first mapped window and number of mapped windows for a page size.
  function automatic int unsigned first_win(int unsigned page_bits);
    return 32'(MAP_LO) >> page_bits;
  endfunction

  function automatic int unsigned num_win(int unsigned page_bits);
    return (32'(MAP_HI) - 32'(MAP_LO) + 32'd1) >> page_bits;
  endfunction

endpackage

// File: rtl/mapper_bank_regfile.sv
// Per-id bank/SRAM registers for the mapped windows plus the one-commit-per-request FSM.
module mapper_bank_regfile
  import mapper_banked_gen_pkg::*;
#(
  parameter int unsigned NUM_IDS   = 2,
  parameter int unsigned PAGE_BITS = 14,
  parameter int unsigned BANK_W    = 3,
  parameter bank_mode_t  BANK_MODE = BANK_PAIR,
  parameter int          SRAM_BIT  = -1,
  localparam int unsigned NMAP     = num_win(PAGE_BITS),
  localparam int unsigned K_W      = $clog2(NMAP),
  localparam int unsigned IDX_W    = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_hit,
  input  logic              i_req,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [K_W-1:0]    i_wr_slot,
  input  logic [7:0]        i_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  input  logic [K_W-1:0]    i_rd_slot,
  output logic [BANK_W-1:0] o_bank,
  output logic              o_sram
);

  localparam int unsigned NSETS = 1 << IDX_W;

  logic [BANK_W-1:0] r_bank [NSETS][NMAP];
  logic              r_sram [NSETS][NMAP];
  commit_st_t        r_state;
  commit_st_t        w_state_next;
  logic              w_commit;
  logic [BANK_W-1:0] w_new_bank;
  logic              w_new_sram;
  logic              w_unused_data;

  assign w_unused_data = ^i_data;

  always_comb begin
    w_new_bank = '0;
    if (BANK_MODE == BANK_PAIR) begin
      w_new_bank[1:0] = {i_data[0], i_wr_slot[0]};
    end else begin
      w_new_bank = i_data[BANK_W-1:0];
    end
  end

  if (SRAM_BIT >= 0) begin : g_sram
    assign w_new_sram = i_data[SRAM_BIT];
  end else begin : g_no_sram
    assign w_new_sram = 1'b0;
  end

  // A request held over many cycles commits only on its first cycle.
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_wr_hit) begin
          w_commit     = 1'b1;
          w_state_next = StHeld;
        end
      end
      StHeld: begin
        if (!i_req) begin
          w_state_next = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      for (int i = 0; i < int'(NSETS); i++) begin
        for (int j = 0; j < int'(NMAP); j++) begin
          r_bank[i][j] <= BANK_W'(j);
          r_sram[i][j] <= 1'b0;
        end
      end
    end else begin
      r_state <= w_state_next;
      if (w_commit) begin
        r_bank[i_wr_idx][i_wr_slot] <= w_new_bank;
        r_sram[i_wr_idx][i_wr_slot] <= w_new_sram;
      end
    end
  end

  assign o_bank = r_bank[i_rd_idx][i_rd_slot];
  assign o_sram = r_sram[i_rd_idx][i_rd_slot];

endmodule

// File: rtl/mapper_banked_gen.sv
// Banked ROM/SRAM cartridge mapper: address decode, range/wrap arithmetic and output muxing.
module mapper_banked_gen
  import mapper_banked_gen_pkg::*;
#(
  parameter mapper_typ_t MAPPER_TYPE = MAPPER_HARRY_FOX,
  parameter int unsigned NUM_IDS     = 2,
  parameter int unsigned PAGE_BITS   = 14,
  parameter int unsigned BANK_W      = 3,
  parameter bank_mode_t  BANK_MODE   = BANK_PAIR,
  parameter int          SRAM_BIT    = -1,
  parameter bit          WRAP        = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [15:0]           i_addr,
  input  logic [7:0]            i_data,
  input  logic                  i_mreq,
  input  logic                  i_rd,
  input  logic                  i_wr,
  input  logic                  i_req,
  input  logic [TYP_W-1:0]      i_typ,
  input  logic [ID_W-1:0]       i_id,
  input  logic [SIZE_W-1:0]     i_rom_size,
  input  logic [SIZE_W-1:0]     i_sram_size,
  output logic                  o_ram_cs,
  output logic [OUT_ADDR_W-1:0] o_addr,
  output logic                  o_sram_cs,
  output logic                  o_rnw
);

  localparam int unsigned FIRST = first_win(PAGE_BITS);
  localparam int unsigned NMAP  = num_win(PAGE_BITS);
  localparam int unsigned K_W   = $clog2(NMAP);
  localparam int unsigned WIN_W = 16 - PAGE_BITS;
  localparam int unsigned IDX_W = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;

  logic [WIN_W-1:0]  w_win;
  logic [K_W-1:0]    w_rd_slot;
  logic [K_W-1:0]    w_wr_slot;
  logic              w_en;
  logic              w_cs;
  logic              w_mapped;
  logic              w_in_reg;
  logic              w_sram_wr_rng;
  logic              w_wr_hit;
  logic [BANK_W-1:0] w_bank;
  logic              w_sram;
  logic [SIZE_W-1:0] w_lin;
  logic [SIZE_W-1:0] w_rom_addr;
  logic              w_rom_ok;
  logic [SIZE_W-1:0] w_sram_addr;
  logic              w_unused_rd;

  // Reads are implied by !wr; rd+wr together is a write.
  assign w_unused_rd = i_rd;

  assign w_en          = (i_typ == MAPPER_TYPE) && (32'(i_id) < NUM_IDS);
  assign w_cs          = w_en && i_mreq && !i_reset;
  assign w_win         = i_addr[15:PAGE_BITS];
  assign w_rd_slot     = K_W'(w_win - WIN_W'(FIRST));
  assign w_wr_slot     = i_addr[12 -: K_W];
  assign w_mapped      = (i_addr >= MAP_LO) && (i_addr <= MAP_HI);
  assign w_in_reg      = (i_addr >= REG_LO) && (i_addr <= REG_HI);
  assign w_sram_wr_rng = (i_addr >= SRAM_WR_LO) && (i_addr <= SRAM_WR_HI);
  assign w_wr_hit      = w_cs && i_wr && i_req && w_in_reg;

  mapper_bank_regfile #(
    .NUM_IDS  (NUM_IDS),
    .PAGE_BITS(PAGE_BITS),
    .BANK_W   (BANK_W),
    .BANK_MODE(BANK_MODE),
    .SRAM_BIT (SRAM_BIT)
  ) u_regfile (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wr_hit (w_wr_hit),
    .i_req    (i_req),
    .i_wr_idx (i_id[IDX_W-1:0]),
    .i_wr_slot(w_wr_slot),
    .i_data   (i_data),
    .i_rd_idx (i_id[IDX_W-1:0]),
    .i_rd_slot(w_rd_slot),
    .o_bank   (w_bank),
    .o_sram   (w_sram)
  );

  assign w_lin      = SIZE_W'({w_bank, i_addr[PAGE_BITS-1:0]});
  assign w_rom_addr = WRAP ? (w_lin & (i_rom_size - SIZE_W'(1))) : w_lin;
  assign w_rom_ok   = WRAP || (w_lin < i_rom_size);
  // SRAM sits directly after ROM; sram_size is a power of two so the modulo is a mask.
  assign w_sram_addr = i_rom_size + (w_lin & (i_sram_size - SIZE_W'(1)));

  always_comb begin
    o_ram_cs  = 1'b0;
    o_sram_cs = 1'b0;
    o_rnw     = 1'b1;
    o_addr    = '1;
    if (w_cs && w_mapped) begin
      if (w_sram) begin
        if ((i_sram_size != '0) && (!i_wr || w_sram_wr_rng)) begin
          o_ram_cs  = 1'b1;
          o_sram_cs = 1'b1;
          o_rnw     = !i_wr;
          o_addr    = OUT_ADDR_W'(w_sram_addr);
        end
      end else if (!i_wr && w_rom_ok) begin
        o_ram_cs = 1'b1;
        o_addr   = OUT_ADDR_W'(w_rom_addr);
      end
    end
  end

endmodule

// File: tb/tb_mapper_banked_gen.sv
// Table-driven scoreboard bench for mapper_banked_gen across three parameterisations.
module tb_mapper_banked_gen;
  import mapper_banked_gen_pkg::*;

  localparam logic [26:0] X1 = 27'h7FFFFFF;

  typedef struct {
    int          inst;
    bit          typ_ok;
    bit          rst;
    logic [3:0]  id;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          mreq;
    bit          rd;
    bit          wr;
    bit          req;
    bit          e_ram;
    bit          e_sram;
    bit          e_rnw;
    logic [26:0] e_addr;
  } vec_t;

  typedef struct {
    int          inst;
    int          tag;
    bit          e_ram;
    bit          e_sram;
    bit          e_rnw;
    logic [26:0] e_addr;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      addr;
  logic [7:0]       data;
  logic             mreq, rd, wr, req;
  logic [3:0]       id;
  logic [TYP_W-1:0] typ [3];
  logic             ram_cs  [3];
  logic             sram_cs [3];
  logic             rnw     [3];
  logic [26:0]      o_addr  [3];

  exp_t sb[$];
  vec_t tbl1[$];
  vec_t tbl2[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tag   = 0;

  always #5 clk = ~clk;

  // A: 16 KB pages, paired banks, SRAM on bit 4, no wrap.
  mapper_banked_gen #(
    .PAGE_BITS(14), .BANK_MODE(BANK_PAIR), .SRAM_BIT(4), .WRAP(1'b0)
  ) u_a (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_data(data), .i_mreq(mreq), .i_rd(rd),
    .i_wr(wr), .i_req(req), .i_typ(typ[0]), .i_id(id), .i_rom_size(28'h0010000),
    .i_sram_size(28'h0002000), .o_ram_cs(ram_cs[0]), .o_addr(o_addr[0]),
    .o_sram_cs(sram_cs[0]), .o_rnw(rnw[0])
  );

  // B: 8 KB pages, direct banks, ROM mirrored.
  mapper_banked_gen #(
    .PAGE_BITS(13), .BANK_MODE(BANK_DIRECT), .SRAM_BIT(-1), .WRAP(1'b1)
  ) u_b (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_data(data), .i_mreq(mreq), .i_rd(rd),
    .i_wr(wr), .i_req(req), .i_typ(typ[1]), .i_id(id), .i_rom_size(28'h0008000),
    .i_sram_size(28'h0000000), .o_ram_cs(ram_cs[1]), .o_addr(o_addr[1]),
    .o_sram_cs(sram_cs[1]), .o_rnw(rnw[1])
  );

  // C: as B but out-of-range ROM is unmapped.
  mapper_banked_gen #(
    .PAGE_BITS(13), .BANK_MODE(BANK_DIRECT), .SRAM_BIT(-1), .WRAP(1'b0)
  ) u_c (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_data(data), .i_mreq(mreq), .i_rd(rd),
    .i_wr(wr), .i_req(req), .i_typ(typ[2]), .i_id(id), .i_rom_size(28'h0008000),
    .i_sram_size(28'h0000000), .o_ram_cs(ram_cs[2]), .o_addr(o_addr[2]),
    .o_sram_cs(sram_cs[2]), .o_rnw(rnw[2])
  );

  function automatic vec_t mk(int inst, bit r, logic [3:0] i, logic [15:0] a, logic [7:0] d,
                              bit w, bit q, bit er, bit es, bit ew, logic [26:0] ea);
    vec_t v;
    v.inst = inst; v.typ_ok = 1'b1; v.rst = r; v.id = i; v.addr = a; v.data = d;
    v.mreq = 1'b1; v.rd = !w; v.wr = w; v.req = q;
    v.e_ram = er; v.e_sram = es; v.e_rnw = ew; v.e_addr = ea;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst = v.rst; id = v.id; addr = v.addr; data = v.data;
    mreq = v.mreq; rd = v.rd; wr = v.wr; req = v.req;
    for (int i = 0; i < 3; i++) begin
      typ[i] = (i == v.inst && v.typ_ok) ? MAPPER_HARRY_FOX : MAPPER_NONE;
    end
    tag++;
    e.inst = v.inst; e.tag = tag;
    e.e_ram = v.e_ram; e.e_sram = v.e_sram; e.e_rnw = v.e_rnw; e.e_addr = v.e_addr;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if ({ram_cs[e.inst], sram_cs[e.inst], rnw[e.inst], o_addr[e.inst]} !==
          {e.e_ram, e.e_sram, e.e_rnw, e.e_addr}) begin
        n_bad++;
        $display("FAIL step%0d inst%0d: got ram_cs=%b sram_cs=%b rnw=%b addr=%h, want %b %b %b %h",
                 e.tag, e.inst, ram_cs[e.inst], sram_cs[e.inst], rnw[e.inst], o_addr[e.inst],
                 e.e_ram, e.e_sram, e.e_rnw, e.e_addr);
      end
    end
  end

  initial begin
    vec_t v;
    // Instance A: reset state and basic bank switching.
    tbl1.push_back(mk(0, 0, 0, 16'h4000, 8'h00, 0, 0, 1, 0, 1, 27'h0000000));
    tbl1.push_back(mk(0, 0, 0, 16'h8123, 8'h00, 0, 0, 1, 0, 1, 27'h0004123));
    tbl1.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 1, X1));
    tbl1.push_back(mk(0, 0, 0, 16'hC000, 8'h00, 0, 0, 0, 0, 1, X1));
    tbl1.push_back(mk(0, 0, 0, 16'hBFFF, 8'h00, 0, 0, 1, 0, 1, 27'h0007FFF));
    tbl1.push_back(mk(0, 0, 0, 16'h3FFF, 8'h00, 0, 0, 0, 0, 1, X1));
    v = mk(0, 0, 0, 16'h4000, 8'h00, 0, 0, 0, 0, 1, X1); v.mreq = 1'b0; tbl1.push_back(v);
    tbl1.push_back(mk(0, 0, 0, 16'h6000, 8'h01, 1, 1, 0, 0, 1, X1));
    tbl1.push_back(mk(0, 0, 0, 16'h4000, 8'h00, 0, 0, 1, 0, 1, 27'h0008000));
    tbl1.push_back(mk(0, 0, 0, 16'h7000, 8'h01, 1, 1, 0, 0, 1, X1));
    tbl1.push_back(mk(0, 0, 0, 16'h8000, 8'h00, 0, 0, 1, 0, 1, 27'h000C000));
    tbl1.push_back(mk(0, 0, 0, 16'h4000, 8'h00, 0, 0, 1, 0, 1, 27'h0008000));
    // Instance A: SRAM banking.
    tbl2.push_back(mk(0, 0, 0, 16'h7000, 8'h10, 1, 1, 0, 0, 1, X1));
    tbl2.push_back(mk(0, 0, 0, 16'h8005, 8'h00, 0, 0, 1, 1, 1, 27'h0010005));
    tbl2.push_back(mk(0, 0, 0, 16'h8005, 8'hAA, 1, 0, 1, 1, 0, 27'h0010005));
    v = mk(0, 0, 0, 16'h9FFF, 8'h12, 1, 0, 1, 1, 0, 27'h0011FFF); v.rd = 1'b1; tbl2.push_back(v);
    tbl2.push_back(mk(0, 0, 0, 16'hA000, 8'h00, 0, 0, 1, 1, 1, 27'h0010000));
    tbl2.push_back(mk(0, 0, 0, 16'h6005, 8'h10, 1, 1, 0, 0, 1, X1));
    tbl2.push_back(mk(0, 0, 0, 16'h4005, 8'h00, 0, 0, 1, 1, 1, 27'h0010005));
    tbl2.push_back(mk(0, 0, 0, 16'h4005, 8'h55, 1, 0, 0, 0, 1, X1));
    tbl2.push_back(mk(0, 0, 0, 16'h6005, 8'h55, 1, 0, 0, 0, 1, X1));
    v = mk(0, 0, 0, 16'h8005, 8'h00, 0, 0, 0, 0, 1, X1); v.typ_ok = 1'b0; tbl2.push_back(v);
    // Instance B: 8 KB direct, wrap.
    tbl2.push_back(mk(1, 0, 0, 16'h4000, 8'h00, 0, 0, 1, 0, 1, 27'h0000000));
    tbl2.push_back(mk(1, 0, 0, 16'h8000, 8'h00, 0, 0, 1, 0, 1, 27'h0004000));
    tbl2.push_back(mk(1, 0, 0, 16'h6000, 8'h00, 0, 0, 1, 0, 1, 27'h0002000));
    tbl2.push_back(mk(1, 0, 0, 16'h7800, 8'h07, 1, 1, 0, 0, 1, X1));
    tbl2.push_back(mk(1, 0, 0, 16'hA000, 8'h00, 0, 0, 1, 0, 1, 27'h0006000));
    tbl2.push_back(mk(1, 0, 0, 16'h7000, 8'h05, 1, 1, 0, 0, 1, X1));
    tbl2.push_back(mk(1, 0, 0, 16'h8010, 8'h00, 0, 0, 1, 0, 1, 27'h0002010));
    tbl2.push_back(mk(1, 0, 0, 16'h6000, 8'hF9, 1, 1, 0, 0, 1, X1));
    tbl2.push_back(mk(1, 0, 0, 16'h4000, 8'h00, 0, 0, 1, 0, 1, 27'h0002000));
    tbl2.push_back(mk(1, 0, 0, 16'hC000, 8'h00, 0, 0, 0, 0, 1, X1));
    tbl2.push_back(mk(1, 0, 0, 16'h3FFF, 8'h00, 0, 0, 0, 0, 1, X1));
    // Instance C: 8 KB direct, no wrap.
    tbl2.push_back(mk(2, 0, 0, 16'h7800, 8'h07, 1, 1, 0, 0, 1, X1));
    tbl2.push_back(mk(2, 0, 0, 16'hA000, 8'h00, 0, 0, 0, 0, 1, X1));
    tbl2.push_back(mk(2, 0, 0, 16'h7800, 8'h03, 1, 1, 0, 0, 1, X1));
    tbl2.push_back(mk(2, 0, 0, 16'hBFFF, 8'h00, 0, 0, 1, 0, 1, 27'h0007FFF));
    tbl2.push_back(mk(2, 0, 0, 16'h7800, 8'h04, 1, 1, 0, 0, 1, X1));
    tbl2.push_back(mk(2, 0, 0, 16'hA000, 8'h00, 0, 0, 0, 0, 1, X1));
    tbl2.push_back(mk(2, 0, 0, 16'h4000, 8'h00, 0, 0, 1, 0, 1, 27'h0000000));

    rst = 1'b1; id = '0; addr = '0; data = '0; mreq = 1'b0; rd = 1'b0; wr = 1'b0; req = 1'b0;
    for (int i = 0; i < 3; i++) typ[i] = MAPPER_NONE;
    repeat (2) @(posedge clk);

    foreach (tbl1[i]) drive(tbl1[i]);

    // Held request: only the first cycle's data commits.
    for (int c = 0; c < 5; c++) begin
      drive(mk(0, 0, 0, 16'h6000, (c < 2) ? 8'h00 : 8'h01, 1, 1, 0, 0, 1, X1));
    end
    drive(mk(0, 0, 0, 16'h4000, 8'h00, 0, 0, 1, 0, 1, 27'h0000000));
    drive(mk(0, 0, 0, 16'h6000, 8'h01, 1, 1, 0, 0, 1, X1));
    drive(mk(0, 0, 0, 16'h4000, 8'h00, 0, 0, 1, 0, 1, 27'h0008000));

    foreach (tbl2[i]) drive(tbl2[i]);

    // Reset while HELD, then commit without dropping req; then id switching.
    drive(mk(0, 0, 0, 16'h6000, 8'h01, 1, 1, 0, 0, 1, X1));
    drive(mk(0, 1, 0, 16'h4000, 8'h00, 0, 1, 0, 0, 1, X1));
    drive(mk(0, 0, 0, 16'h4000, 8'h00, 0, 1, 1, 0, 1, 27'h0000000));
    drive(mk(0, 0, 0, 16'h6000, 8'h01, 1, 1, 0, 0, 1, X1));
    drive(mk(0, 0, 0, 16'h4000, 8'h00, 0, 1, 1, 0, 1, 27'h0008000));
    drive(mk(0, 0, 0, 16'h8000, 8'h00, 0, 0, 1, 0, 1, 27'h0004000));
    drive(mk(0, 0, 1, 16'h4000, 8'h00, 0, 0, 1, 0, 1, 27'h0000000));
    drive(mk(0, 0, 1, 16'h7000, 8'h01, 1, 1, 0, 0, 1, X1));
    drive(mk(0, 0, 1, 16'h8000, 8'h00, 0, 0, 1, 0, 1, 27'h000C000));
    drive(mk(0, 0, 0, 16'h8000, 8'h00, 0, 0, 1, 0, 1, 27'h0004000));
    drive(mk(0, 0, 0, 16'h4000, 8'h00, 0, 0, 1, 0, 1, 27'h0008000));
    drive(mk(0, 0, 2, 16'h4000, 8'h00, 0, 0, 0, 0, 1, X1));

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mapper_banked_gen.md
# mapper_banked_gen

Parametrised ROM/SRAM bank-switching mapper for MSX cartridge slots, the generalised successor of the fixed two-register 16 KB pair mapper. It sits behind the slot decoder, on `cpu_bus` / `block_info` / `mapper_out` like every other mapper. It adds:
- 8 KB or 16 KB pages;
- direct or paired bank-number modes;
- optional SRAM banking;
- ROM mirroring;
- one-commit-per-request write handshake.

## Interface
- `MAPPER_TYPE`, default `MAPPER_HARRY_FOX`: `block_info.typ` value that enables this instance.
- `NUM_IDS`, default 2: bank-register sets, one per `block_info.id`.
- `PAGE_BITS`, default 14: 14 gives 16 KB pages (4 windows); 13 gives 8 KB pages (8 windows).
- `BANK_W`, default 3: stored bank-number width.
- `BANK_MODE`, default `BANK_PAIR`: `BANK_PAIR` gives bank = {data[0], slot-index LSB}; `BANK_DIRECT` gives bank = data[BANK_W-1:0].
- `SRAM_BIT`, default -1: data bit that selects SRAM for a window; -1 disables SRAM.
- `WRAP`, default 0: 1 mirrors ROM modulo `rom_size`; 0 unmaps addresses at or above `rom_size`.
- `cpu_bus.clk`  in  1  system clock; everything is on its rising edge.
- `cpu_bus.reset`  in  1  synchronous, active-high reset.
- `cpu_bus.addr`  in  16  CPU address.
- `cpu_bus.data`  in  8  write data.
- `cpu_bus.mreq`, `.rd`, `.wr`, `.req`  in  1 each  memory strobes; `req` marks an active access.
- `block_info.typ`, `.id`, `.rom_size`, `.sram_size`  in  (package widths)  block configuration.
- `out.ram_cs`  out  1  ROM/SRAM access select.
- `out.addr`  out  27  linear memory address; all ones when not selected.
- `out.sram_cs`  out  1  access targets SRAM (subset of `ram_cs`).
- `out.rnw`  out  1  1 = read, 0 = SRAM write.

## Operation
- Enable `en = (typ == MAPPER_TYPE) && (id < NUM_IDS)`. Chip select `cs = en && mreq`.
- Window index `w = addr[15:PAGE_BITS]`.
- Mapped windows cover 0x4000–0xBFFF: windows 1–2 when `PAGE_BITS`=14, windows 2–5 when `PAGE_BITS`=13. All other windows are permanently unmapped.
- Per id, each mapped window has a register {sram, bank[BANK_W-1:0]}.
- Register writes hit 0x6000–0x7FFF. Slot index `k` = `addr[12]` (16 KB) or `addr[12:11]` (8 KB); it selects the k-th mapped window.
- Write value:
  - `BANK_PAIR`: bank = {data[0], k[0]}.
  - `BANK_DIRECT`: bank = data.
  - sram = data[SRAM_BIT], only when `SRAM_BIT` ≥ 0.
- Reset values: the k-th mapped window gets bank = k, sram = 0. This gives 16 KB banks 0,1 and 8 KB banks 0..3.
- Reads, unmapped window: `ram_cs`=0.
- Reads, ROM window: rom_addr = {zero-pad, bank, addr[PAGE_BITS-1:0]}.
  - `WRAP`=1: address ANDed with (`rom_size`-1); `rom_size` must be a power of two.
  - `WRAP`=0: `ram_cs`=0 when rom_addr ≥ `rom_size`.
- SRAM window: sram_addr = (bank × 2^PAGE_BITS + offset) mod `sram_size`, placed after ROM (base = `rom_size`). `sram_cs`=1.
  - Writes are accepted only in 0x8000–0xBFFF; `rnw`=0 on writes.
  - `sram_size`=0 forces `sram_cs`=0.
- Register writes never assert `ram_cs`, except when the target window is SRAM-mapped and inside 0x8000–0xBFFF. 0x6000–0x7FFF is never SRAM-writable.
- `rd` and `wr` both high: treated as write.

## Timing
- Read path is combinational from registers: zero-cycle latency.
- Commit handshake FSM per instance, states IDLE and HELD:
  - IDLE → HELD on `cs && wr && req` inside the register range; the register is written at that edge.
  - In HELD, further writes are ignored.
  - HELD → IDLE on the first cycle with `req`=0.
  - A `req` held for N cycles commits exactly once.
- New bank is visible to reads from the cycle after the commit edge.
- Reset:
  - Any cycle with reset high restores all register sets and sets FSM to IDLE, including mid-HELD.
  - While reset is high, outputs are forced: `ram_cs`=`sram_cs`=0, `rnw`=1, `addr`=all ones.
- Outputs when `cs`=0: `ram_cs`=`sram_cs`=0, `rnw`=1, `addr`=all ones.
- Id switch: an id change takes effect immediately. Registers of the other id are untouched.

## Structure
- Shared mapper package:
  - `bank_mode_t` {`BANK_DIRECT`, `BANK_PAIR`}.
  - Register-window constants `REG_LO`=0x6000, `REG_HI`=0x7FFF.
  - Mapped-window range constants.
- One sub-module, `mapper_bank_regfile`: per-id register array, reset values, commit FSM. Outputs {sram, bank} for (id, w).
- Top level holds address decode, range/wrap arithmetic and output muxing.

## Test plan
- Reset, 16 KB `BANK_PAIR`, `rom_size`=64 KB:
  - read 0x4000 → `addr`=0x00000, `ram_cs`=1;
  - read 0x8123 → `addr`=0x04123;
  - read 0x0000 and 0xC000 → `ram_cs`=0, `addr`=all ones.
- Write 0x01 to 0x6000, then 0x01 to 0x7000:
  - read 0x4000 → 0x08000;
  - read 0x8000 → 0x0C000;
  - the write cycles themselves show `ram_cs`=0.
- Hold `req` 5 cycles while writing 0x00 to 0x6000 and changing data to 0x01 mid-hold → only 0x00 is committed. Drop `req`, write 0x01 → commits.
- 8 KB `BANK_DIRECT`, `WRAP`=1, `rom_size`=32 KB:
  - write 0x07 to 0x7800 → read 0xA000 gives `addr`=0x6000 (bank 7 mirrored to 3);
  - with `WRAP`=0, the same read gives `ram_cs`=0.
- `SRAM_BIT`=4, `rom_size`=64 KB, `sram_size`=8 KB:
  - write 0x10 to 0x7000 (16 KB), then write 0xAA to 0x8005 → `sram_cs`=1, `rnw`=0, `addr`=0x10005;
  - write to 0x6005 → no `ram_cs`.
- Reset asserted in HELD and after bank writes → next read 0x4000 gives 0x00000; a new write commits without `req` toggling first. `id`=2 with `NUM_IDS`=2 → `ram_cs` stays 0.
